// File: rtl/sc_psr_flags.sv
// Processor-status / condition-code stage: registers ALU icc flags, evaluates SPARC branch
// conditions, offers PSR read/write, and keeps an icc save-stack. Optional macro: SC_PSR_FLAG_BYPASS_EN.
module sc_psr_flags #(
    parameter int DATAWIDTH_BUS = 32,
    parameter int STACK_DEPTH   = 4,
    parameter int ICC_LSB       = 20
) (
    input  logic                     SC_PSR_CLOCK_50,
    input  logic                     SC_PSR_RESET_InHigh,
    input  logic                     SC_PSR_overflow_InLow,
    input  logic                     SC_PSR_carry_InLow,
    input  logic                     SC_PSR_negative_InLow,
    input  logic                     SC_PSR_zero_InLow,
    input  logic                     SC_PSR_SetCode_In,
    input  logic                     SC_PSR_load_InHigh,
    input  logic                     SC_PSR_write_InHigh,
    input  logic [DATAWIDTH_BUS-1:0] SC_PSR_data_InBus,
    input  logic                     SC_PSR_push_InHigh,
    input  logic                     SC_PSR_pop_InHigh,
    input  logic [3:0]               SC_PSR_cond_InBus,
    output logic [3:0]               SC_PSR_icc_OutBus,
    output logic [DATAWIDTH_BUS-1:0] SC_PSR_data_OutBus,
    output logic                     SC_PSR_branch_Out,
    output logic                     SC_PSR_full_Out,
    output logic                     SC_PSR_empty_Out,
    output logic                     SC_PSR_error_OutHigh
);

    localparam int AW  = $clog2(STACK_DEPTH);
    localparam int SPW = AW + 1;

    logic [3:0]     icc;
    logic [3:0]     icc_next;
    logic [3:0]     alu_flags;
    logic [3:0]     wr_flags;
    logic [3:0]     br_flags;
    logic [3:0]     stack [STACK_DEPTH];
    logic [SPW-1:0] sp;
    logic [SPW-1:0] sp_next;
    logic [SPW-1:0] sp_dec;
    logic           full;
    logic           empty;
    logic           error;
    logic           flag_set;
    logic           push_ok;
    logic           pop_ok;
    logic           misuse;
    logic           unused_data_bits;

    assign alu_flags = ~{SC_PSR_negative_InLow, SC_PSR_zero_InLow,
                         SC_PSR_overflow_InLow, SC_PSR_carry_InLow};
    assign wr_flags  = SC_PSR_data_InBus[ICC_LSB+3:ICC_LSB];
    assign flag_set  = SC_PSR_load_InHigh & SC_PSR_SetCode_In;
    assign sp_dec    = sp - SPW'(1);
    // Only the icc field of the write bus is architecturally meaningful.
    assign unused_data_bits = ^SC_PSR_data_InBus;

    always_comb begin
        push_ok  = SC_PSR_push_InHigh & ~SC_PSR_pop_InHigh & ~full;
        pop_ok   = SC_PSR_pop_InHigh & ~SC_PSR_push_InHigh & ~empty;
        misuse   = (SC_PSR_push_InHigh & SC_PSR_pop_InHigh)
                 | (SC_PSR_push_InHigh & ~SC_PSR_pop_InHigh & full)
                 | (SC_PSR_pop_InHigh & ~SC_PSR_push_InHigh & empty);
        sp_next  = sp;
        if (push_ok) begin
            sp_next = sp + SPW'(1);
        end else if (pop_ok) begin
            sp_next = sp_dec;
        end
        icc_next = icc;
        if (pop_ok) begin
            icc_next = stack[sp_dec[AW-1:0]];
        end else if (SC_PSR_write_InHigh) begin
            icc_next = wr_flags;
        end else if (flag_set) begin
            icc_next = alu_flags;
        end
    end

    always_ff @(posedge SC_PSR_CLOCK_50 or posedge SC_PSR_RESET_InHigh) begin
        if (SC_PSR_RESET_InHigh) begin
            icc   <= '0;
            sp    <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
            error <= 1'b0;
        end else begin
            icc   <= icc_next;
            sp    <= sp_next;
            full  <= (sp_next == SPW'(STACK_DEPTH));
            empty <= (sp_next == '0);
            error <= error | misuse;
        end
    end

    // Stack contents need no reset: sp guards every read.
    always_ff @(posedge SC_PSR_CLOCK_50) begin
        if (push_ok) begin
            stack[sp[AW-1:0]] <= icc;
        end
    end

    function automatic logic eval_cond(input logic [3:0] f, input logic [3:0] cond);
        logic n, z, v, c, base;
        {n, z, v, c} = f;
        case (cond[2:0])
            3'b000:  base = 1'b0;
            3'b001:  base = z;
            3'b010:  base = z | (n ^ v);
            3'b011:  base = n ^ v;
            3'b100:  base = c | z;
            3'b101:  base = c;
            3'b110:  base = n;
            default: base = v;
        endcase
        return base ^ cond[3];
    endfunction

    always_comb begin
`ifdef SC_PSR_FLAG_BYPASS_EN
        if (SC_PSR_write_InHigh) begin
            br_flags = wr_flags;
        end else if (flag_set) begin
            br_flags = alu_flags;
        end else begin
            br_flags = icc;
        end
`else
        br_flags = icc;
`endif
    end

    always_comb begin
        SC_PSR_data_OutBus = '0;
        SC_PSR_data_OutBus[ICC_LSB+:4] = icc;
    end

    assign SC_PSR_branch_Out    = eval_cond(br_flags, SC_PSR_cond_InBus);
    assign SC_PSR_icc_OutBus    = icc;
    assign SC_PSR_full_Out      = full;
    assign SC_PSR_empty_Out     = empty;
    assign SC_PSR_error_OutHigh = error;

endmodule

// File: tb/tb_sc_psr_flags.sv
// Scoreboard bench for sc_psr_flags: a reference model queues expected state per cycle.
module tb_sc_psr_flags;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LSB   = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          ovf_n, carry_n, neg_n, zero_n;
    logic          set_code, load, write, push, pop;
    logic [DW-1:0] data_in;
    logic [3:0]    cond;
    logic [3:0]    icc;
    logic [DW-1:0] data_out;
    logic          branch, full, empty, error;

    sc_psr_flags #(.DATAWIDTH_BUS(DW), .STACK_DEPTH(DEPTH), .ICC_LSB(LSB)) dut (
        .SC_PSR_CLOCK_50      (clk),
        .SC_PSR_RESET_InHigh  (rst),
        .SC_PSR_overflow_InLow(ovf_n),
        .SC_PSR_carry_InLow   (carry_n),
        .SC_PSR_negative_InLow(neg_n),
        .SC_PSR_zero_InLow    (zero_n),
        .SC_PSR_SetCode_In    (set_code),
        .SC_PSR_load_InHigh   (load),
        .SC_PSR_write_InHigh  (write),
        .SC_PSR_data_InBus    (data_in),
        .SC_PSR_push_InHigh   (push),
        .SC_PSR_pop_InHigh    (pop),
        .SC_PSR_cond_InBus    (cond),
        .SC_PSR_icc_OutBus    (icc),
        .SC_PSR_data_OutBus   (data_out),
        .SC_PSR_branch_Out    (branch),
        .SC_PSR_full_Out      (full),
        .SC_PSR_empty_Out     (empty),
        .SC_PSR_error_OutHigh (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] icc;
        logic       full;
        logic       empty;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] m_stack[$];
    logic [3:0] m_icc;
    logic       m_err;
    int         n_tests = 0;
    int         n_fail  = 0;
`ifdef SC_PSR_FLAG_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference branch table written out per full 4-bit condition code.
    function automatic logic br_model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, v, cy;
        {n, z, v, cy} = f;
        case (c)
            4'b0000: return 1'b0;
            4'b0001: return z;
            4'b0010: return z | (n ^ v);
            4'b0011: return n ^ v;
            4'b0100: return cy | z;
            4'b0101: return cy;
            4'b0110: return n;
            4'b0111: return v;
            4'b1000: return 1'b1;
            4'b1001: return !z;
            4'b1010: return !(z | (n ^ v));
            4'b1011: return !(n ^ v);
            4'b1100: return !(cy | z);
            4'b1101: return !cy;
            4'b1110: return !n;
            default: return !v;
        endcase
    endfunction

    task automatic idle();
        {neg_n, zero_n, ovf_n, carry_n} = 4'hF;
        set_code = 1'b0; load = 1'b0; write = 1'b0;
        push = 1'b0; pop = 1'b0; data_in = '0;
    endtask

    task automatic model_reset();
        m_icc = 4'h0;
        m_err = 1'b0;
        m_stack.delete();
        sb.delete();
    endtask

    task automatic apply(input logic ld, input logic sc, input logic [3:0] alu_lo,
                         input logic wr, input logic [31:0] d, input logic pu, input logic po);
        exp_t       e;
        logic [3:0] old;
        logic       push_ok, pop_ok;
        {neg_n, zero_n, ovf_n, carry_n} = alu_lo;
        load = ld; set_code = sc; write = wr; data_in = d; push = pu; pop = po;
        old     = m_icc;
        push_ok = pu && !po && (m_stack.size() < DEPTH);
        pop_ok  = po && !pu && (m_stack.size() != 0);
        if ((pu && po) || (pu && !po && m_stack.size() == DEPTH) || (po && !pu && m_stack.size() == 0))
            m_err = 1'b1;
        if (ld && sc) m_icc = ~alu_lo;
        if (wr) m_icc = d[LSB+3:LSB];
        if (pop_ok) m_icc = m_stack.pop_back();
        if (push_ok) m_stack.push_back(old);
        e.icc   = m_icc;
        e.full  = (m_stack.size() == DEPTH);
        e.empty = (m_stack.size() == 0);
        e.err   = m_err;
        sb.push_back(e);
    endtask

    task automatic settle();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("icc", 32'(icc), 32'(e.icc));
            check("data_out", data_out, 32'(e.icc) << LSB);
            check("full", 32'(full), 32'(e.full));
            check("empty", 32'(empty), 32'(e.empty));
            check("error", 32'(error), 32'(e.err));
        end
        idle();
    endtask

    task automatic step(input logic ld, input logic sc, input logic [3:0] alu_lo,
                        input logic wr, input logic [31:0] d, input logic pu, input logic po);
        apply(ld, sc, alu_lo, wr, d, pu, po);
        settle();
    endtask

    task automatic wr_icc(input logic [3:0] v, input logic pu);
        step(1'b0, 1'b0, 4'hF, 1'b1, 32'(v) << LSB, pu, 1'b0);
    endtask

    task automatic check_branch(input logic [3:0] c);
        cond = c;
        #1;
        check($sformatf("branch_%b", c), 32'(branch), 32'(br_model(c, m_icc)));
    endtask

    initial begin
        idle();
        cond = 4'b0000;
        rst  = 1'b1;
        model_reset();
        #1;
        check("rst_icc", 32'(icc), 32'h0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_data", data_out, 32'h0);
        check_branch(4'b1000);
        check_branch(4'b0000);
        #10 rst = 1'b0;

        // ALU capture: Z and C asserted (active low)
        step(1'b1, 1'b1, 4'b1010, 1'b0, 32'h0, 1'b0, 1'b0);
        check("alu_icc", 32'(icc), 32'h5);
        check("alu_data", data_out, 32'h0050_0000);
        check_branch(4'b0001);
        check_branch(4'b1101);
        step(1'b1, 1'b0, 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0);
        check("nosetcode_icc", 32'(icc), 32'h5);

        step(1'b0, 1'b0, 4'hF, 1'b1, 32'h00A0_0000, 1'b0, 1'b0);
        check("write_icc", 32'(icc), 32'hA);
        check_branch(4'b0011);
        check_branch(4'b1110);
        check_branch(4'b0110);
        step(1'b0, 1'b0, 4'hF, 1'b1, 32'hFF5F_FFFF, 1'b0, 1'b0);
        check("write_mask", data_out, 32'h0050_0000);
        step(1'b1, 1'b1, 4'b0000, 1'b1, 32'h0030_0000, 1'b0, 1'b0);
        check("write_over_load", 32'(icc), 32'h3);

        // Fill the stack; each push saves the pre-write icc
        wr_icc(4'b0001, 1'b0);
        wr_icc(4'b0010, 1'b1);
        wr_icc(4'b0100, 1'b1);
        wr_icc(4'b1000, 1'b1);
        step(1'b0, 1'b0, 4'hF, 1'b0, 32'h0, 1'b1, 1'b0);
        check("full_after_4", 32'(full), 32'd1);
        step(1'b0, 1'b0, 4'hF, 1'b0, 32'h0, 1'b1, 1'b0);
        check("push_full_err", 32'(error), 32'd1);
        step(1'b0, 1'b0, 4'hF, 1'b0, 32'h0, 1'b0, 1'b1);
        check("pop1", 32'(icc), 32'h8);
        step(1'b0, 1'b0, 4'hF, 1'b0, 32'h0, 1'b0, 1'b1);
        check("pop2", 32'(icc), 32'h4);
        step(1'b0, 1'b0, 4'hF, 1'b0, 32'h0, 1'b0, 1'b1);
        check("pop3", 32'(icc), 32'h2);
        step(1'b0, 1'b0, 4'hF, 1'b0, 32'h0, 1'b0, 1'b1);
        check("pop4", 32'(icc), 32'h1);
        check("empty_after_4", 32'(empty), 32'd1);
        step(1'b0, 1'b0, 4'hF, 1'b0, 32'h0, 1'b0, 1'b1);
        check("pop_empty_hold", 32'(icc), 32'h1);

        // Push with load in the same cycle, then pop with write
        wr_icc(4'b0011, 1'b0);
        step(1'b1, 1'b1, 4'b0111, 1'b0, 32'h0, 1'b1, 1'b0);
        check("push_load_icc", 32'(icc), 32'h8);
        step(1'b0, 1'b0, 4'hF, 1'b1, 32'h00F0_0000, 1'b0, 1'b1);
        check("pop_over_write", 32'(icc), 32'h3);

        for (int i = 0; i < 4; i++) begin
            wr_icc(4'($urandom_range(0, 15)), 1'b0);
            for (int c = 0; c < 16; c++) check_branch(4'(c));
        end

        // Flag forwarding: branch on incoming Z in the load cycle
        wr_icc(4'b0000, 1'b0);
        apply(1'b1, 1'b1, 4'b1011, 1'b0, 32'h0, 1'b0, 1'b0);
        cond = 4'b0001;
        #1;
        check("bypass_same_cycle", 32'(branch), 32'(BYPASS));
        settle();
        cond = 4'b0001;
        #1;
        check("branch_next_cycle", 32'(branch), 32'd1);

        // Mid-run async reset with icc=1111, sp=2, error set
        wr_icc(4'b1111, 1'b1);
        step(1'b0, 1'b0, 4'hF, 1'b0, 32'h0, 1'b1, 1'b0);
        check("pre_rst_icc", 32'(icc), 32'hF);
        check("pre_rst_error", 32'(error), 32'd1);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("mid_rst_icc", 32'(icc), 32'h0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_error", 32'(error), 32'd0);
        check_branch(4'b1000);
        check_branch(4'b0000);
        @(negedge clk);
        rst = 1'b0;

        step(1'b0, 1'b0, 4'hF, 1'b0, 32'h0, 1'b1, 1'b1);
        check("push_pop_err", 32'(error), 32'd1);
        check("push_pop_empty", 32'(empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sc_psr_flags.md
Name: sc_psr_flags

Overview:
- Processor-status / condition-code stage directly downstream of the datapath ALU.
- Registers the ALU's active-low N/Z/V/C flags when the ALU asserts its set-code output.
- Provides SPARC-style branch-condition evaluation to microcontrol, a PSR read/write path on the data bus, and a small LIFO that saves and restores icc across traps.

Parameters:
- DATAWIDTH_BUS, 32, width of PSR data in/out buses.
- STACK_DEPTH, 4, icc save-stack entries; power of 2, minimum 2.
- ICC_LSB, 20, bit position of C in the PSR word; the icc field {N,Z,V,C} occupies [ICC_LSB+3:ICC_LSB].

Ports:
- SC_PSR_CLOCK_50  in  1  system clock, rising edge.
- SC_PSR_RESET_InHigh  in  1  asynchronous, active-high reset.
- SC_PSR_overflow_InLow  in  1  ALU V flag, active low.
- SC_PSR_carry_InLow  in  1  ALU C flag, active low.
- SC_PSR_negative_InLow  in  1  ALU N flag, active low.
- SC_PSR_zero_InLow  in  1  ALU Z flag, active low.
- SC_PSR_SetCode_In  in  1  ALU op is flag-setting (ADDCC class).
- SC_PSR_load_InHigh  in  1  ALU result valid this cycle; qualifies SetCode.
- SC_PSR_write_InHigh  in  1  direct PSR write (wr %psr).
- SC_PSR_data_InBus  in  DATAWIDTH_BUS  PSR write data.
- SC_PSR_push_InHigh  in  1  save current icc to stack.
- SC_PSR_pop_InHigh  in  1  restore icc from stack.
- SC_PSR_cond_InBus  in  4  branch condition select.
- SC_PSR_icc_OutBus  out  4  registered {N,Z,V,C}, active high.
- SC_PSR_data_OutBus  out  DATAWIDTH_BUS  icc at ICC_LSB position; all other bits 0.
- SC_PSR_branch_Out  out  1  selected condition is true.
- SC_PSR_full_Out  out  1  stack holds STACK_DEPTH entries.
- SC_PSR_empty_Out  out  1  stack holds 0 entries.
- SC_PSR_error_OutHigh  out  1  sticky stack-misuse flag.

Behaviour:
- Reset (async, immediate): icc=0000, stack pointer=0, empty=1, full=0, error=0, data_Out=0. branch_Out follows cond with zero flags (e.g. 1000 gives 1).
- Flag capture: on rising edge with load=1 and SetCode=1, icc <= {~negative_InLow, ~zero_InLow, ~overflow_InLow, ~carry_InLow}. load=1 with SetCode=0 leaves icc unchanged. Latency is 1 cycle: visible on icc_OutBus the cycle after.
- Write: write=1 loads icc <= data_InBus[ICC_LSB+3:ICC_LSB]; other bits are ignored.
- icc update priority within one edge: pop > write > load.
- Push (push=1, pop=0, not full): stack[sp] <= current registered icc (pre-update value); sp+1. A load or write in the same cycle still updates icc.
- Pop (pop=1, push=0, not empty): icc <= stack[sp-1]; sp-1.
- Push on full: no store, sp unchanged, error <= 1.
- Pop on empty: icc unchanged, sp unchanged, error <= 1. Write/load in that cycle still apply.
- push=1 and pop=1 together: no stack operation, error <= 1. Write/load still apply.
- error clears only on reset.
- full and empty are registered, derived from sp in the range 0..STACK_DEPTH; no wrap-around.
- Branch evaluation is combinational on registered icc. cond[3]=1 inverts the cond[2:0] result:
  - 000 never
  - 001 Z
  - 010 Z|(N^V)
  - 011 N^V
  - 100 C|Z
  - 101 C
  - 110 N
  - 111 V
  - Hence 1000 always, 1001 ne, 1010 g, 1011 ge, 1100 gu, 1101 cc, 1110 pos, 1111 vc.

Optional Feature:
- SC_PSR_FLAG_BYPASS_EN defined: when load=1 and SetCode=1, branch_Out evaluates on the incoming (inverted) ALU flags in the same cycle (forwarding). Priority: write data, then ALU flags, then registered icc; pop is not bypassed. icc_OutBus stays registered.
- Macro undefined: branch_Out uses registered icc only, giving 1-cycle flag-to-branch latency.

Test Plan:
- Reset mid-run with icc=1111 and sp=2 -> immediately icc=0000, empty=1, error=0; cond=1000 gives branch=1, cond=0000 gives branch=0.
- ALU inputs zero_InLow=0, carry_InLow=0, others 1, SetCode=1, load=1 -> next cycle icc=0101, data_Out=0x00500000, cond=0001 gives 1, cond=1101 gives 0. Same inputs with SetCode=0 -> icc unchanged.
- write=1, data_InBus=0x00A00000 -> icc=1010, cond=0011 (N^V) gives 0, cond=1110 gives 0, cond=0110 gives 1.
- Push 4 distinct icc values (0001, 0010, 0100, 1000) -> full=1; 5th push -> error=1, sp unchanged. 4 pops return 1000, 0100, 0010, 0001, then empty=1. Another pop -> icc holds 0001.
- Same cycle push + load with new flags 1000 from icc=0011 -> stack top=0011, icc=1000. Same cycle pop + write -> icc = popped value.
- With SC_PSR_FLAG_BYPASS_EN: load+SetCode with zero_InLow=0, cond=0001 -> branch=1 in the same cycle. Without the macro -> branch=1 only on the next cycle.
